// File: rtl/event_pkg.sv
// Shared types for the event arbiter: default field widths, event record
// and output-stage state.
package event_pkg;

   localparam int XW_DEF = 16;
   localparam int YW_DEF = 16;
   localparam int TW_DEF = 16;

   typedef struct packed {
      logic [XW_DEF-1:0] x;
      logic [YW_DEF-1:0] y;
      logic [TW_DEF-1:0] t;
      logic              p;
   } event_t;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after 'last',
// wrapping modulo N.
module rr_picker #(
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] last,
   output logic [N-1:0]  gnt_onehot,
   output logic [SW-1:0] gnt_idx,
   output logic          any
);

   always_comb begin
      int idx;
      idx        = 0;
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      // last < N and k <= N, so one conditional subtract implements the wrap
      for (int k = 1; k <= N; k++) begin
         idx = int'(last) + k;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx]) begin
            any             = 1'b1;
            gnt_idx         = SW'(idx);
            gnt_onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/event_arbiter.sv
// Round-robin arbiter feeding one registered event output stage.
// Optional macro EVT_ARB_DROP_NEG_EN drops p=0 winners and counts them.
module event_arbiter
   import event_pkg::*;
#(
   parameter  int N_SRC = 4,
   parameter  int XW    = XW_DEF,
   parameter  int YW    = YW_DEF,
   parameter  int TW    = TW_DEF,
   localparam int SW    = $clog2(N_SRC)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [N_SRC-1:0]    in_valid,
   output logic [N_SRC-1:0]    in_ready,
   input  logic [N_SRC*XW-1:0] in_x,
   input  logic [N_SRC*YW-1:0] in_y,
   input  logic [N_SRC*TW-1:0] in_t,
   input  logic [N_SRC-1:0]    in_p,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XW-1:0]       out_x,
   output logic [YW-1:0]       out_y,
   output logic [TW-1:0]       out_t,
   output logic                out_p,
   output logic [SW-1:0]       out_src,
   output logic                busy
`ifdef EVT_ARB_DROP_NEG_EN
   ,
   output logic [15:0]         drop_cnt
`endif
);

   logic [N_SRC-1:0] gnt_onehot;
   logic [SW-1:0]    gnt_idx;
   logic             any;
   logic [SW-1:0]    last_p0;
   stage_t           state_p0;

   logic [XW-1:0] win_x;
   logic [YW-1:0] win_y;
   logic [TW-1:0] win_t;
   logic          win_p;
   logic          drain_ok;
   logic          ld_ok;
   logic          hs;
   logic          fwd;

   rr_picker #(.N(N_SRC)) u_picker (
      .req        (in_valid),
      .last       (last_p0),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (any)
   );

   assign win_x = in_x[int'(gnt_idx)*XW +: XW];
   assign win_y = in_y[int'(gnt_idx)*YW +: YW];
   assign win_t = in_t[int'(gnt_idx)*TW +: TW];
   assign win_p = in_p[gnt_idx];

   assign drain_ok = (state_p0 == EMPTY) | out_ready;

`ifdef EVT_ARB_DROP_NEG_EN
   // A p=0 winner is consumed without touching the output stage
   assign ld_ok = enable & ((any & ~win_p) | drain_ok);
   assign fwd   = hs & win_p;
`else
   assign ld_ok = enable & drain_ok;
   assign fwd   = hs;
`endif

   assign hs        = ld_ok & any & ~rst;
   assign in_ready  = hs ? gnt_onehot : '0;
   assign out_valid = (state_p0 == FULL);
   assign busy      = out_valid | (|in_valid);

   // Output stage p0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p0 <= EMPTY;
         last_p0  <= SW'(N_SRC - 1);
         out_x    <= '0;
         out_y    <= '0;
         out_t    <= '0;
         out_p    <= 1'b0;
         out_src  <= '0;
      end else begin
         if (hs) last_p0 <= gnt_idx;
         if (fwd) begin
            out_x   <= win_x;
            out_y   <= win_y;
            out_t   <= win_t;
            out_p   <= win_p;
            out_src <= gnt_idx;
         end
         case (state_p0)
            EMPTY:   if (fwd) state_p0 <= FULL;
            FULL:    if (!fwd && out_ready) state_p0 <= EMPTY;
            default: state_p0 <= EMPTY;
         endcase
      end
   end

`ifdef EVT_ARB_DROP_NEG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (hs && !win_p && drop_cnt != 16'hFFFF) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_event_arbiter.sv
// Directed bench for event_arbiter: vector table for arbitration and
// handshake rules, plus hand sequences for stall, reset and drop cases.
module tb_event_arbiter;
   import event_pkg::*;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic [N*16-1:0] in_x, in_y, in_t;
   logic [N-1:0]  in_p;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_x, out_y, out_t;
   logic          out_p;
   logic [1:0]    out_src;
   logic          busy;
`ifdef EVT_ARB_DROP_NEG_EN
   logic [15:0]   drop_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   event_arbiter #(.N_SRC(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_t      (in_t),
      .in_p      (in_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_t     (out_t),
      .out_p     (out_p),
      .out_src   (out_src),
      .busy      (busy)
`ifdef EVT_ARB_DROP_NEG_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  iv;
      logic        en;
      logic        ordy;
      logic [3:0]  exp_ir;
      logic        exp_ov;
      logic [1:0]  exp_src;
      logic [15:0] exp_x;
   } vec_t;

   vec_t vt[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_src(input int i, input event_t e);
      in_x[i*16 +: 16] = e.x;
      in_y[i*16 +: 16] = e.y;
      in_t[i*16 +: 16] = e.t;
      in_p[i]          = e.p;
   endtask

   initial begin
      event_t e;
      //          iv       en    ordy  exp_ir   ov    src    x
      vt[0]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0, 16'h0000};
      vt[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd0, 16'h0010};
      vt[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd1, 16'h0011};
      vt[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd2, 16'h0012};
      vt[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd3, 16'h0013};
      vt[5]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 16'h0010};
      vt[6]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0010};
      vt[7]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0, 16'h0010};
      vt[8]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h0011};
      vt[9]  = '{4'b0010, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 16'h0011};
      vt[10] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 16'h0011};
      vt[11] = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b0, 2'd1, 16'h0011};
      vt[12] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 16'h0012};
      vt[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h0012};

      rst       = 1'b1;
      enable    = 1'b1;
      out_ready = 1'b1;
      in_valid  = 4'b1111;
      in_x = '0; in_y = '0; in_t = '0; in_p = '0;
      for (int i = 0; i < N; i++) begin
         e = '{x: 16'h0010 + 16'(i), y: 16'h0100 + 16'(i), t: 16'h1000 + 16'(i), p: 1'b1};
         set_src(i, e);
      end

      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_x",     32'(out_x),     32'd0);
      check("rst_busy",      32'(busy),      32'd1);
      rst = 1'b0;

      for (int r = 0; r < 14; r++) begin
         in_valid  = vt[r].iv;
         enable    = vt[r].en;
         out_ready = vt[r].ordy;
         #1;
         check($sformatf("vec%0d_in_ready", r),  32'(in_ready),  32'(vt[r].exp_ir));
         check($sformatf("vec%0d_out_valid", r), 32'(out_valid), 32'(vt[r].exp_ov));
         check($sformatf("vec%0d_out_src", r),   32'(out_src),   32'(vt[r].exp_src));
         check($sformatf("vec%0d_out_x", r),     32'(out_x),     32'(vt[r].exp_x));
         @(negedge clk);
      end

      // Stall: source 2 alone, downstream not ready for three cycles
      e = '{x: 16'h1234, y: 16'h0042, t: 16'hBEEF, p: 1'b1};
      set_src(2, e);
      in_valid  = 4'b0100;
      enable    = 1'b1;
      out_ready = 1'b0;
      #1;
      check("stall_first_grant", 32'(in_ready), 32'b0100);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("stall_in_ready",  32'(in_ready),  32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_out_x",     32'(out_x),     32'h1234);
         check("stall_out_y",     32'(out_y),     32'h0042);
         check("stall_out_t",     32'(out_t),     32'hBEEF);
         check("stall_out_p",     32'(out_p),     32'd1);
         check("stall_out_src",   32'(out_src),   32'd2);
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_x[2*16 +: 16] = 16'h5678;
      #1;
      check("release_in_ready", 32'(in_ready), 32'b0100);
      check("release_old_x",    32'(out_x),    32'h1234);
      @(negedge clk);
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      #1;
      check("reload_out_valid", 32'(out_valid), 32'd1);
      check("reload_out_x",     32'(out_x),     32'h5678);
      check("reload_out_src",   32'(out_src),   32'd2);

      // Asynchronous reset while FULL
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_out_x",     32'(out_x),     32'd0);
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      check("post_rst_grant", 32'(in_ready), 32'b0001);
      @(negedge clk);
      in_valid = 4'b0000;
      #1;
      check("post_rst_out_valid", 32'(out_valid), 32'd1);
      check("post_rst_out_src",   32'(out_src),   32'd0);
      check("post_rst_out_x",     32'(out_x),     32'h0010);
      @(negedge clk);

`ifdef EVT_ARB_DROP_NEG_EN
      #1;
      check("drop_cnt_init", 32'(drop_cnt), 32'd0);
      in_valid = 4'b0010;
      in_p[1]  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("drop_in_ready",  32'(in_ready),  32'b0010);
         check("drop_out_valid", 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      in_p[1] = 1'b1;
      #1;
      check("keep_in_ready", 32'(in_ready), 32'b0010);
      @(negedge clk);
      in_valid = 4'b0000;
      #1;
      check("keep_out_valid", 32'(out_valid), 32'd1);
      check("keep_out_src",   32'(out_src),   32'd1);
      check("drop_cnt_5",     32'(drop_cnt),  32'd5);
      in_valid = 4'b0010;
      in_p[1]  = 1'b0;
      repeat (65530) @(negedge clk);
      #1;
      check("drop_cnt_full", 32'(drop_cnt), 32'hFFFF);
      @(negedge clk);
      #1;
      check("drop_cnt_sat", 32'(drop_cnt), 32'hFFFF);
      check("drop_sat_out_valid", 32'(out_valid), 32'd0);
      in_valid = 4'b0000;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/event_arbiter.md
Name: event_arbiter

Overview:
- Round-robin arbiter that shares one downstream event filter between N_SRC event sources (sensor tiles / readout lanes).
- Each source offers one {x, y, t, p} event per valid/ready handshake.
- The arbiter picks one source per cycle and loads the event into a single registered output stage, tagged with the source index.
- Sits directly in front of the event filter; sustains one event per clock when downstream is always ready.

Parameters:
- N_SRC, 4, number of requesting sources (2..8)
- XW, 16, x coordinate width
- YW, 16, y coordinate width
- TW, 16, timestamp width
- SW, $clog2(N_SRC), source-index width (derived localparam, not overridable)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  when low, no new grants are issued
- in_valid  in  N_SRC  per-source event valid
- in_ready  out  N_SRC  per-source accept, one-hot or zero
- in_x  in  N_SRC*XW  packed x, source i at [i*XW +: XW]
- in_y  in  N_SRC*YW  packed y
- in_t  in  N_SRC*TW  packed timestamp
- in_p  in  N_SRC  polarity
- out_valid  out  1  output event valid
- out_ready  in  1  filter accepts output event
- out_x  out  XW  granted x
- out_y  out  YW  granted y
- out_t  out  TW  granted t
- out_p  out  1  granted p
- out_src  out  SW  index of the source the event came from
- busy  out  1  out_valid OR any in_valid

Behaviour:
- Reset (async, rst=1):
  - out_valid=0; out_x/out_y/out_t/out_p/out_src=0.
  - Round-robin pointer last=N_SRC-1, so source 0 has first priority.
  - in_ready=0 while rst is high.
- Output stage is two-state: EMPTY (out_valid=0) and FULL (out_valid=1).
- load = enable & (~out_valid | out_ready). Draining and reloading in the same cycle is legal, giving full throughput.
- Grant selection (combinational):
  - Search in_valid in order last+1, last+2, … wrapping modulo N_SRC. The first set bit is the winner g.
  - With no valid source there is no winner.
- in_ready[i] = load & winner_exists & (i==g). in_ready depends combinationally on in_valid; sources must not make in_valid depend on in_ready.
- On a handshake (in_valid[g] & in_ready[g]):
  - Next edge: out_* <= source g fields, out_src<=g, out_valid<=1, last<=g.
  - Latency is one cycle from handshake to out_valid.
- If out_ready & out_valid with no new load: out_valid<=0; data regs keep their last value.
- FULL & ~out_ready: all outputs stable; no in_ready asserted.
- Pointer behaviour:
  - last changes only on a handshake.
  - Single continuous requester i: granted every cycle, last stays i.
  - All N_SRC valid continuously: grants cycle 0,1,…,N_SRC-1,0.
- enable low:
  - No in_ready; the current FULL event is still drained by out_ready.
  - Re-enabling resumes from the unchanged pointer.
- Reset mid-transfer: the pending output event is discarded; sources must re-present.
- Data fields pass unmodified; no arithmetic on x/y/t.

Optional Feature:
- Macro: EVT_ARB_DROP_NEG_EN.
- Defined:
  - A winning event with in_p=0 is still handshaken (in_ready asserted, pointer advances) but is not loaded; out_valid follows the drain rule only.
  - Adds output port drop_cnt (16 bits), which increments per dropped event, saturates at 16'hFFFF, and resets to 0.
  - load for a p=0 winner requires only enable. Dropping never stalls on out_ready.
- Undefined:
  - All events are forwarded, p is passed through, and the drop_cnt port is absent.

Decomposition:
- Package event_pkg holds:
  - default width constants (XW/YW/TW=16);
  - the event struct {x, y, t, p};
  - the output-stage state enum {EMPTY, FULL}.
- One sub-module, rr_picker:
  - parameter N;
  - inputs req[N], last[SW];
  - outputs gnt_onehot[N], gnt_idx[SW], any.
  - Purely combinational; reused later by other shared-resource arbiters.

Test Plan:
- Reset with all in_valid=4'b1111 → out_valid=0, in_ready=0; after release, first grant source 0 and out_src=0 one cycle later.
- in_valid=4'b1111 held, out_ready=1, distinct x per source (0x0010,0x0011,0x0012,0x0013) → out_src sequence 0,1,2,3,0, one event per clock, out_x matches.
- Source 2 only, x=0x1234, y=0x0042, t=0xBEEF, p=1, out_ready=0 for 3 cycles → out_valid=1 and fields stable, in_ready=0 until out_ready=1, then the next event loads the same cycle.
- enable=0 while FULL, out_ready=1 → event drains, no new in_ready; enable=1 → grant resumes at last+1.
- Assert rst mid-stream while FULL → out_valid=0 immediately (async), pointer back to 3, first grant after release is source 0.
- With EVT_ARB_DROP_NEG_EN: source 1 sends p=0 five times, then p=1 → out_valid only for the p=1 event, drop_cnt=5; preload drop_cnt to 16'hFFFF → remains 16'hFFFF after a further drop.
